// File: rtl/param_mem_pkg.sv
// Shared types and address helpers for the burst memory model and its row tracker.
// Latency: none; this file holds only types and a combinational helper.
// Backpressure: none.
package param_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [63:0] row;
  } bank_row_t;

  // Page number = addr >> page_sh; the low bank_sh bits of the page pick the
  // bank and everything above them is the row.
  function automatic bank_row_t calc_bank_row(input logic [63:0] addr,
                                              input int page_sh,
                                              input int bank_sh);
    bank_row_t   r;
    logic [63:0] pg;
    pg     = addr >> page_sh;
    r.bank = 32'(pg & ((64'd1 << bank_sh) - 64'd1));
    r.row  = pg >> bank_sh;
    return r;
  endfunction

endpackage

// File: rtl/param_mem_row_tracker.sv
// Open-row tracker: one valid bit and one row register per bank.
// Latency: hit is combinational from bank/row; the open row updates on the lookup edge.
// Backpressure: none; a lookup is taken whenever the strobe is high.
module param_mem_row_tracker
  import param_mem_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int ROW_W     = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic              lookup,
  output logic              hit
);

  logic [NUM_BANKS-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]     row_q [NUM_BANKS];
  logic [ROW_W-1:0]     row_d [NUM_BANKS];

  assign hit = valid_q[bank] && (row_q[bank] == row);

  // A lookup always leaves the addressed bank open on the requested row.
  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    if (lookup) begin
      valid_d[bank] = 1'b1;
      row_d[bank]   = row;
    end
  end

  // Per-bank state; reset closes every bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/param_burst_mem.sv
// Line-burst memory model with open-row latency (hit/miss); stats under PARAM_MEM_STATS_EN.
// Latency: first beat HIT_CYCLES or MISS_CYCLES after accept, then BURST_LEN back-to-back beats.
// Backpressure: requests are only taken in IDLE; inputs are ignored while a burst is in flight.
module param_burst_mem
  import param_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_LEN   = 4,
  parameter int DEPTH_LINES = 512,
  parameter int NUM_BANKS   = 4,
  parameter int PAGE_BYTES  = 256,
  parameter int MISS_CYCLES = 50,
  parameter int HIT_CYCLES  = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [DATA_W-1:0] pmem_wdata,
  output logic [DATA_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              pmem_err,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_row_hits,
  output logic [31:0]       stat_row_misses
);

  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int LINE_W  = $clog2(DEPTH_LINES);
  localparam int LINE_SH = $clog2(DATA_W / 8 * BURST_LEN);
  localparam int PAGE_SH = $clog2(PAGE_BYTES);
  localparam int BANK_SH = $clog2(NUM_BANKS);
  localparam int BANK_W  = (BANK_SH > 0) ? BANK_SH : 1;
  localparam int ROW_W   = ADDR_W - PAGE_SH - BANK_SH;
  localparam int MAX_LAT = (MISS_CYCLES > HIT_CYCLES) ? MISS_CYCLES : HIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int WORDS   = DEPTH_LINES * BURST_LEN;

  state_t              state_q, state_d;
  dir_t                dir_q, dir_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_q, resp_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [WORDS];
  logic                wr_en;

  bank_row_t           br;
  logic [BANK_W-1:0]   req_bank;
  logic [ROW_W-1:0]    req_row;
  logic [LINE_W-1:0]   req_line;
  logic                acc_vld;
  logic                row_hit;
  logic                unused_bits;

  assign br       = calc_bank_row(64'(pmem_address), PAGE_SH, BANK_SH);
  assign req_bank = br.bank[BANK_W-1:0];
  assign req_row  = br.row[ROW_W-1:0];
  // Offset bits below the line and address bits above the array both drop out.
  assign req_line = pmem_address[LINE_SH +: LINE_W];
  assign acc_vld  = (state_q == ST_IDLE) && (pmem_read ^ pmem_write);
  assign unused_bits = ^{pmem_address, br};

  param_mem_row_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W),
    .ROW_W     (ROW_W)
  ) u_row_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .bank   (req_bank),
    .row    (req_row),
    .lookup (acc_vld),
    .hit    (row_hit)
  );

  // Next-state for the IDLE -> WAIT -> BURST -> IDLE sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    line_d  = line_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_vld) begin
          dir_d   = pmem_write ? DIR_WRITE : DIR_READ;
          line_d  = req_line;
          // Counter holds L-1 so the first beat lands exactly L edges after accept.
          cnt_d   = row_hit ? CNT_W'(HIT_CYCLES - 1) : CNT_W'(MISS_CYCLES - 1);
          state_d = ST_WAIT;
        end else if (pmem_read && pmem_write) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_BURST;
          beat_d  = '0;
          resp_d  = 1'b1;
          if (dir_q == DIR_READ) rdata_d = mem[{line_q, BEAT_W'(0)}];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BURST: begin
        wr_en = (dir_q == DIR_WRITE);
        if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          resp_d = 1'b1;
          if (dir_q == DIR_READ) rdata_d = mem[{line_q, beat_q + BEAT_W'(1)}];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_READ;
      line_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately unreset; a write beat lands on the edge that ends it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{line_q, beat_q}] <= pmem_wdata;
  end

  assign pmem_resp  = resp_q;
  assign pmem_err   = err_q;
  assign pmem_rdata = rdata_q;

`ifdef PARAM_MEM_STATS_EN
  logic [31:0] st_rd_q, st_rd_d;
  logic [31:0] st_wr_q, st_wr_d;
  logic [31:0] st_hit_q, st_hit_d;
  logic [31:0] st_miss_q, st_miss_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters, bumped once per accepted request.
  always_comb begin
    st_rd_d   = st_rd_q;
    st_wr_d   = st_wr_q;
    st_hit_d  = st_hit_q;
    st_miss_d = st_miss_q;
    if (acc_vld) begin
      if (pmem_write) st_wr_d = sat_inc(st_wr_q);
      else            st_rd_d = sat_inc(st_rd_q);
      if (row_hit)    st_hit_d  = sat_inc(st_hit_q);
      else            st_miss_d = sat_inc(st_miss_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_rd_q   <= '0;
      st_wr_q   <= '0;
      st_hit_q  <= '0;
      st_miss_q <= '0;
    end else begin
      st_rd_q   <= st_rd_d;
      st_wr_q   <= st_wr_d;
      st_hit_q  <= st_hit_d;
      st_miss_q <= st_miss_d;
    end
  end

  assign stat_reads      = st_rd_q;
  assign stat_writes     = st_wr_q;
  assign stat_row_hits   = st_hit_q;
  assign stat_row_misses = st_miss_q;
`else
  assign stat_reads      = '0;
  assign stat_writes     = '0;
  assign stat_row_hits   = '0;
  assign stat_row_misses = '0;
`endif

endmodule
